axi4_rd_arbiter: RTL and testbench
==================================

# axi4_rd_arbiter

Two-to-one AXI4 read-channel arbiter sharing one downstream read slave (AR + R channels) between two upstream read masters. Grants AR requests round-robin and widens the ID by one bit to tag the source. Routes R beats back to the source by that bit. Sits between the transaction-layer RX read requesters and the shared AXI4 memory-side port.

## Interface
- ID_WIDTH, 4, upstream ID width; downstream ID is ID_WIDTH+1
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 256, read data width
- MAX_OUTSTANDING, 4, per-master limit on open bursts (only with the macro)

Ports:
- aclk  in  1  clock; all logic on posedge
- areset  in  1  synchronous, active-high reset
- s_arvalid  in  2  per-master AR valid; bit i = master i
- s_arready  out  2  per-master AR ready
- s_arid  in  2*ID_WIDTH  packed, master i at [i*ID_WIDTH +: ID_WIDTH]
- s_araddr  in  2*ADDR_WIDTH  packed addresses
- s_arlen / s_arsize / s_arburst  in  16 / 6 / 4  packed len, size, burst
- m_arvalid  out  1  downstream AR valid
- m_arready  in  1  downstream AR ready
- m_arid  out  ID_WIDTH+1  {source index, upstream ID}
- m_araddr / m_arlen / m_arsize / m_arburst  out  ADDR_WIDTH / 8 / 3 / 2  granted request fields
- m_rvalid / m_rlast  in  1 / 1  downstream R valid, last
- m_rready  out  1  downstream R ready
- m_rid  in  ID_WIDTH+1  returned tagged ID
- m_rdata / m_rresp  in  DATA_WIDTH / 2  read data, response
- s_rvalid  out  2  per-master R valid
- s_rready  in  2  per-master R ready
- s_rid / s_rdata / s_rresp / s_rlast  out  ID_WIDTH / DATA_WIDTH / 2 / 1  broadcast to both masters

## Operation
- AR FSM: IDLE, HOLD.
- In IDLE: m_arvalid=0. Grant is computed from eligible s_arvalid bits and rr pointer. The pointer names the preferred master; if only one master is eligible, it wins.
- s_arready[g]=1 only for the granted master g, only in IDLE. The other bit is 0.
- Handshake on master g: latch its fields, m_arid <= {g, s_arid[g]}, go to HOLD. Pointer <= ~g.
- In HOLD: m_arvalid=1 and registered fields hold stable. On m_arready go to IDLE. s_arready=0 in HOLD.
- R path is combinational with zero latency. idx = m_rid[ID_WIDTH].
  - s_rvalid[idx] = m_rvalid; the other bit is 0.
  - m_rready = s_rready[idx].
  - s_rid = m_rid[ID_WIDTH-1:0].
  - s_rdata, s_rresp and s_rlast are passed through to both masters.
- R and AR are independent; R beats flow in any FSM state.

## Timing
- Reset values: FSM=IDLE, pointer=0, m_arvalid=0, s_arready=0, latched AR fields=0, counters=0.
- AR latency: upstream handshake in cycle N → m_arvalid=1 in N+1.
- Peak AR throughput: one request per 2 cycles (IDLE→HOLD→IDLE) when m_arready is held high.
- AR fields must not change while m_arvalid && !m_arready.
- Both masters valid in the same cycle: pointer decides. Back-to-back contention alternates 0,1,0,1.
- Reset mid-operation: HOLD is abandoned and outstanding bursts are forgotten. Upstream and downstream are reset together with this block.

## Configuration
- AXI4_RD_ARB_LIMIT_EN: per-master counter, width $clog2(MAX_OUTSTANDING+1).
  - Increment on that master's AR handshake.
  - Decrement on an R handshake with m_rlast routed to that master.
  - Both in the same cycle: value unchanged.
  - A master with count==MAX_OUTSTANDING is ineligible for grant.
  - Simulation assertion: no underflow.
- Undefined: no counters, and every valid master is eligible.

## Structure
- Package axi4_rd_arb_pkg holds the FSM state enum (IDLE, HOLD) and localparam NUM_MASTERS=2.
- Sub-module axi4_rr_arbiter2 holds the pointer register and combinational grant, with inputs req[1:0] and advance.

## Test plan
- Single master: s_arvalid=2'b01, araddr=0x1000, arid=3, m_arready=1 → m_arvalid next cycle, m_arid=5'h03, m_araddr=0x1000.
- Contention: both valid continuously after reset → grants 0,1,0,1. m_arid[4] toggles; one AR per 2 cycles.
- Backpressure: m_arready=0 for 5 cycles → m_arvalid and fields stable, s_arready=2'b00 throughout.
- R routing: m_rid=5'h12, m_rvalid=1, s_rready=2'b10 → s_rvalid=2'b10, s_rid=2, m_rready=1. With s_rready=2'b01 → m_rready=0.
- With AXI4_RD_ARB_LIMIT_EN, MAX_OUTSTANDING=2:
  - Master 0 issues 3 ARs, no R → third not granted, s_arready[0]=0.
  - One rlast beat to master 0 → third granted.
- Reset while in HOLD: areset=1 for 1 cycle → m_arvalid=0 next cycle, pointer=0, counters=0.

Source files
------------

// File: rtl/axi4_rd_arb_pkg.sv
// Shared types for the two-master AXI4 read arbiter.
// Holds the AR state encoding and the fixed master count.
package axi4_rd_arb_pkg;
  localparam int NUM_MASTERS = 2;
  typedef enum logic {IDLE, HOLD} ar_state_t;
endpackage

// File: rtl/axi4_rd_arbiter_if.sv
// AR/R bundle for the arbiter: packed upstream (s_*) side and tagged downstream (m_*) side.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface axi4_rd_arbiter_if
  import axi4_rd_arb_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 256
);
  logic [NUM_MASTERS-1:0]            s_arvalid;
  logic [NUM_MASTERS-1:0]            s_arready;
  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_arid;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr;
  logic [NUM_MASTERS*8-1:0]          s_arlen;
  logic [NUM_MASTERS*3-1:0]          s_arsize;
  logic [NUM_MASTERS*2-1:0]          s_arburst;

  logic                  m_arvalid;
  logic                  m_arready;
  logic [ID_WIDTH:0]     m_arid;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;

  logic                  m_rvalid;
  logic                  m_rlast;
  logic                  m_rready;
  logic [ID_WIDTH:0]     m_rid;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0]            m_rresp;

  logic [NUM_MASTERS-1:0] s_rvalid;
  logic [NUM_MASTERS-1:0] s_rready;
  logic [ID_WIDTH-1:0]    s_rid;
  logic [DATA_WIDTH-1:0]  s_rdata;
  logic [1:0]             s_rresp;
  logic                   s_rlast;

  modport slave (
    input  s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst,
    output s_arready,
    output m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
    input  m_arready,
    input  m_rvalid, m_rlast, m_rid, m_rdata, m_rresp,
    output m_rready,
    output s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
    input  s_rready
  );

  modport master (
    output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst,
    input  s_arready,
    input  m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
    output m_arready,
    output m_rvalid, m_rlast, m_rid, m_rdata, m_rresp,
    input  m_rready,
    input  s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
    output s_rready
  );
endinterface

// File: rtl/axi4_rr_arbiter2.sv
// Two-way round-robin grant: ptr names the preferred requester, a lone requester always wins.
// Grant is combinational from req; ptr moves past the winner when advance is pulsed.
module axi4_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_idx
);
  logic ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~grant_idx;
    end
  end

  always_comb begin
    grant_idx = ptr;
    if (!req[ptr] && req[~ptr]) begin
      grant_idx = ~ptr;
    end
    grant = (|req) ? (2'b01 << grant_idx) : 2'b00;
  end
endmodule

// File: rtl/axi4_rd_arbiter.sv
// 2:1 AXI4 read arbiter: one AR per two cycles (IDLE->HOLD), fields held under m_arready backpressure;
// R beats routed combinationally by m_rid MSB. Optional AXI4_RD_ARB_LIMIT_EN caps open bursts per master.
module axi4_rd_arbiter
  import axi4_rd_arb_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 256
`ifdef AXI4_RD_ARB_LIMIT_EN
  , parameter int MAX_OUTSTANDING = 4
`endif
) (
  input logic              aclk,
  input logic              areset,
  axi4_rd_arbiter_if.slave bus
);
  ar_state_t state, state_nxt;

  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grant;
  logic                   gidx;
  logic                   ar_hs;
  logic                   r_idx;
  logic [DATA_WIDTH-1:0]  r_data;

  logic [ID_WIDTH:0]     id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;

`ifdef AXI4_RD_ARB_LIMIT_EN
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [CW-1:0]          cnt [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] dec_vec;

  // A burst closes on the rlast beat that actually handshakes with its owner.
  assign dec_vec = bus.s_rvalid & bus.s_rready & {NUM_MASTERS{bus.m_rlast}};

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      elig[i] = bus.s_arvalid[i] && (cnt[i] != CW'(MAX_OUTSTANDING));
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_MASTERS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        assert (!(dec_vec[i] && !grant[i] && cnt[i] == '0));
        if (grant[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + CW'(1);
        end else if (dec_vec[i] && !grant[i]) begin
          cnt[i] <= cnt[i] - CW'(1);
        end
      end
    end
  end
`else
  assign elig = bus.s_arvalid;
`endif

  assign req   = (state == IDLE) ? elig : '0;
  assign ar_hs = |grant;

  axi4_rr_arbiter2 u_rr (
    .clk       (aclk),
    .rst       (areset),
    .req       (req),
    .advance   (ar_hs),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.m_arvalid = 1'b0;
    bus.s_arready = '0;
    case (state)
      IDLE: begin
        bus.s_arready = grant;
        if (ar_hs) state_nxt = HOLD;
      end
      HOLD: begin
        bus.m_arvalid = 1'b1;
        if (bus.m_arready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else if (ar_hs) begin
      id_q    <= {gidx, gidx ? bus.s_arid[2*ID_WIDTH-1:ID_WIDTH] : bus.s_arid[ID_WIDTH-1:0]};
      addr_q  <= gidx ? bus.s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.s_araddr[ADDR_WIDTH-1:0];
      len_q   <= gidx ? bus.s_arlen[15:8]    : bus.s_arlen[7:0];
      size_q  <= gidx ? bus.s_arsize[5:3]    : bus.s_arsize[2:0];
      burst_q <= gidx ? bus.s_arburst[3:2]   : bus.s_arburst[1:0];
    end
  end

  assign bus.m_arid    = id_q;
  assign bus.m_araddr  = addr_q;
  assign bus.m_arlen   = len_q;
  assign bus.m_arsize  = size_q;
  assign bus.m_arburst = burst_q;

  assign r_idx        = bus.m_rid[ID_WIDTH];
  assign r_data       = bus.m_rdata;
  assign bus.s_rvalid = r_idx ? {bus.m_rvalid, 1'b0} : {1'b0, bus.m_rvalid};
  assign bus.m_rready = bus.s_rready[r_idx];
  assign bus.s_rid    = bus.m_rid[ID_WIDTH-1:0];
  assign bus.s_rdata  = r_data;
  assign bus.s_rresp  = bus.m_rresp;
  assign bus.s_rlast  = bus.m_rlast;
endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Bench for axi4_rd_arbiter: directed scenarios with literal expectations plus a random phase,
// all cross-checked every cycle against a transaction-level model of the arbiter.
module tb_axi4_rd_arbiter;
  localparam int IDW = 4;
  localparam int AW  = 64;
  localparam int DW  = 256;
`ifdef AXI4_RD_ARB_LIMIT_EN
  localparam bit LIMIT = 1'b1;
  localparam int MAXO  = 2;
`else
  localparam bit LIMIT = 1'b0;
  localparam int MAXO  = 0;
`endif

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi4_rd_arbiter_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_rd_arbiter #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
`ifdef AXI4_RD_ARB_LIMIT_EN
    , .MAX_OUTSTANDING(MAXO)
`endif
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: at most one request is parked downstream; while nothing is parked the
  // preferred eligible master is accepted and preference passes to the other one.
  bit              pend;
  logic [IDW:0]    p_id;
  logic [AW-1:0]   p_addr;
  logic [7:0]      p_len;
  logic [2:0]      p_size;
  logic [1:0]      p_burst;
  int              pref;
  int              mcnt [2];

  always @(negedge aclk) begin : cmp
    int idx;
    int w;
    logic [1:0] exp_rv;
    logic [1:0] exp_rdy;
    idx = int'(bus.m_rid[IDW]);
    exp_rv = bus.m_rvalid ? ((idx == 1) ? 2'b10 : 2'b01) : 2'b00;
    check("s_rvalid", bus.s_rvalid, exp_rv);
    check("m_rready", bus.m_rready, bus.s_rready[idx]);
    check("s_rid", bus.s_rid, bus.m_rid[IDW-1:0]);
    check("s_rdata", bus.s_rdata, bus.m_rdata);
    check("s_rresp", bus.s_rresp, bus.m_rresp);
    check("s_rlast", bus.s_rlast, bus.m_rlast);
    if (areset) begin
      pend = 1'b0;
      pref = 0;
      mcnt[0] = 0;
      mcnt[1] = 0;
    end else begin
      w = -1;
      if (!pend) begin
        for (int k = 0; k < 2; k++) begin
          int m;
          m = (k == 0) ? pref : 1 - pref;
          if (w < 0 && bus.s_arvalid[m] && (!LIMIT || mcnt[m] < MAXO)) w = m;
        end
      end
      exp_rdy = (w < 0) ? 2'b00 : ((w == 1) ? 2'b10 : 2'b01);
      check("m_arvalid", bus.m_arvalid, pend);
      check("s_arready", bus.s_arready, exp_rdy);
      if (pend) begin
        check("m_arid", bus.m_arid, p_id);
        check("m_araddr", bus.m_araddr, p_addr);
        check("m_arlen", bus.m_arlen, p_len);
        check("m_arsize", bus.m_arsize, p_size);
        check("m_arburst", bus.m_arburst, p_burst);
      end
      if (bus.m_rvalid && bus.s_rready[idx] && bus.m_rlast) mcnt[idx]--;
      if (pend && bus.m_arready) pend = 1'b0;
      if (w >= 0) begin
        pend    = 1'b1;
        p_id    = {w[0], bus.s_arid[w*IDW +: IDW]};
        p_addr  = bus.s_araddr[w*AW +: AW];
        p_len   = bus.s_arlen[w*8 +: 8];
        p_size  = bus.s_arsize[w*3 +: 3];
        p_burst = bus.s_arburst[w*2 +: 2];
        pref    = 1 - w;
        mcnt[w]++;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_arvalid = '0; bus.s_arid = '0; bus.s_araddr = '0;
    bus.s_arlen = '0; bus.s_arsize = '0; bus.s_arburst = '0;
    bus.m_arready = 1'b0;
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.m_rid = '0;
    bus.m_rdata = '0; bus.m_rresp = '0; bus.s_rready = '0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    repeat (3) tick();
    areset = 1'b0;

    @(negedge aclk);
    check("reset m_arvalid", bus.m_arvalid, 1'b0);
    check("reset s_arready", bus.s_arready, 2'b00);
    check("reset m_arid", bus.m_arid, 5'h00);
    check("reset m_araddr", bus.m_araddr, 64'h0);

    // Single master request.
    tick();
    bus.s_arvalid = 2'b01; bus.s_arid = 8'h03; bus.s_araddr = {64'h0, 64'h1000};
    bus.m_arready = 1'b1;
    @(negedge aclk);
    check("single s_arready", bus.s_arready, 2'b01);
    tick();
    bus.s_arvalid = 2'b00;
    @(negedge aclk);
    check("single m_arvalid", bus.m_arvalid, 1'b1);
    check("single m_arid", bus.m_arid, 5'h03);
    check("single m_araddr", bus.m_araddr, 64'h1000);
    tick();

    // Continuous contention from reset alternates 0,1,0,1.
    do_reset();
    bus.s_arvalid = 2'b11; bus.s_arid = 8'h96; bus.m_arready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
      check("contend s_arready", bus.s_arready,
            (k % 2 == 1) ? 2'b00 : ((k % 4 == 0) ? 2'b01 : 2'b10));
      check("contend m_arvalid", bus.m_arvalid, (k % 2 == 1));
      if (k % 2 == 1) check("contend m_arid", bus.m_arid, (k % 4 == 1) ? 5'h06 : 5'h19);
      tick();
    end

    // Downstream backpressure: request parked while upstream keeps changing.
    idle_inputs();
    do_reset();
    bus.s_arvalid = 2'b10; bus.s_arid = 8'hA0; bus.s_araddr = {64'hDEAD_0000, 64'h0};
    @(negedge aclk);
    check("bp grant", bus.s_arready, 2'b10);
    for (int k = 0; k < 5; k++) begin
      tick();
      bus.s_arvalid = 2'b11;
      bus.s_araddr = {$urandom, $urandom, $urandom, $urandom};
      @(negedge aclk);
      check("bp m_arvalid", bus.m_arvalid, 1'b1);
      check("bp m_arid", bus.m_arid, 5'h1A);
      check("bp m_araddr", bus.m_araddr, 64'hDEAD_0000);
      check("bp s_arready", bus.s_arready, 2'b00);
    end
    tick();
    bus.s_arvalid = 2'b00; bus.m_arready = 1'b1;
    tick();

    // R routing by tag bit.
    idle_inputs();
    bus.m_rid = 5'h12; bus.m_rvalid = 1'b1; bus.s_rready = 2'b10;
    @(negedge aclk);
    check("r s_rvalid", bus.s_rvalid, 2'b10);
    check("r s_rid", bus.s_rid, 4'h2);
    check("r m_rready", bus.m_rready, 1'b1);
    tick();
    bus.s_rready = 2'b01;
    @(negedge aclk);
    check("r m_rready other", bus.m_rready, 1'b0);
    tick();
    idle_inputs();

`ifdef AXI4_RD_ARB_LIMIT_EN
    // Outstanding limit: third AR from master 0 waits for an rlast.
    do_reset();
    bus.s_arvalid = 2'b01; bus.m_arready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      check("limit s_arready", bus.s_arready, (k == 0 || k == 2) ? 2'b01 : 2'b00);
      tick();
    end
    bus.m_rvalid = 1'b1; bus.m_rid = 5'h00; bus.m_rlast = 1'b1; bus.s_rready = 2'b01;
    @(negedge aclk);
    check("limit still blocked", bus.s_arready, 2'b00);
    tick();
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
    @(negedge aclk);
    check("limit released", bus.s_arready, 2'b01);
    tick();
    idle_inputs();
`endif

    // Reset while parked in HOLD.
    do_reset();
    bus.s_arvalid = 2'b01;
    tick();
    bus.s_arvalid = 2'b00;
    @(negedge aclk);
    check("hold m_arvalid", bus.m_arvalid, 1'b1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    @(negedge aclk);
    check("post-reset m_arvalid", bus.m_arvalid, 1'b0);
    tick();
    bus.s_arvalid = 2'b11;
    @(negedge aclk);
    check("post-reset pointer", bus.s_arready, 2'b01);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int ri;
      areset = ($urandom_range(0, 199) == 0);
      bus.s_arvalid = 2'($urandom);
      bus.s_arid = 8'($urandom);
      bus.s_araddr = {$urandom, $urandom, $urandom, $urandom};
      bus.s_arlen = 16'($urandom);
      bus.s_arsize = 6'($urandom);
      bus.s_arburst = 4'($urandom);
      bus.m_arready = ($urandom_range(0, 3) != 0);
      ri = $urandom_range(0, 1);
      bus.m_rid = {ri[0], 4'($urandom)};
      bus.m_rvalid = $urandom_range(0, 1);
      bus.m_rdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.m_rresp = 2'($urandom);
      bus.s_rready = 2'($urandom);
      bus.m_rlast = ($urandom_range(0, 1) == 1) && !areset && (mcnt[ri] > 0);
      tick();
    end
    idle_inputs();
    areset = 1'b0;
    tick();
    @(negedge aclk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
